pipeline_trace_buffer: RTL

Synthesizable per-cycle trace capture for the pipelined core. It replaces the simulation-only habit of printing EX/MEM state for N cycles and then stopping. Each cycle the pipeline advances, the block records a parametrised multi-channel sample (PC, ALU result, write-back destination, flags) into a circular buffer. It supports pre-trigger history, a selectable trigger, a programmable post-trigger length and a registered readout port. It sits beside the top-level pipeline and taps the EX/MEM outputs.

---
 rtl/pipeline_trace_buffer_pkg.sv | 18 +
 rtl/pipeline_trace_buffer_ram.sv | 39 +++
 rtl/pipeline_trace_buffer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared encodings for the pipeline trace buffer: capture FSM states and trigger modes.
package pipeline_trace_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } trace_state_t;

   typedef enum logic [1:0] {
      TRIG_IMM    = 2'd0,
      TRIG_PC     = 2'd1,
      TRIG_EXT    = 2'd2,
      TRIG_PC_EXT = 2'd3
   } trig_mode_t;

endpackage

// File: rtl/pipeline_trace_buffer_ram.sv
// Simple dual-port sample store: synchronous write, registered read.
// A read and a write to the same entry in one cycle returns the old contents.
module trace_ram #(
   parameter int unsigned WIDTH  = 128,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Storage array is intentionally left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port; clears on reset so the readout starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Per-cycle trace capture beside the pipeline: circular buffer with pre-trigger
// history, selectable trigger, programmable post-trigger length and registered readout.
module pipeline_trace_buffer
   import pipeline_trace_buffer_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NCH    = 4,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  arm,
   input  logic [1:0]            trig_mode,
   input  logic [DATA_W-1:0]     trig_pc,
   input  logic                  ext_trig,
   input  logic [ADDR_W:0]       post_count,
   input  logic                  sample_valid,
   input  logic [DATA_W-1:0]     pc,
   input  logic [NCH*DATA_W-1:0] sample,
   output logic [1:0]            state,
   output logic                  done,
   output logic [ADDR_W:0]       count,
   output logic [ADDR_W-1:0]     trig_index,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [NCH*DATA_W-1:0] rd_data
);

   localparam int unsigned    SAMPLE_W = NCH * DATA_W;
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   trace_state_t      state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic [ADDR_W-1:0] tptr_q, tptr_d;
   trig_mode_t        mode_q, mode_d;
   logic [DATA_W-1:0] trig_pc_q, trig_pc_d;
   logic [ADDR_W:0]   post_q, post_d;

   logic              we;
   logic              trig_hit;
   logic [ADDR_W:0]   post_clamped;
   logic [ADDR_W:0]   count_inc;
   logic [ADDR_W-1:0] oldest;
   logic [ADDR_W-1:0] rd_phys;

   // Post-trigger length must be at least one (the trigger sample) and at most
   // DEPTH, so post-trigger writes can never overwrite the trigger sample.
   always_comb begin
      post_clamped = post_count;
      if (post_count == '0) begin
         post_clamped = CNT_ONE;
      end else if (post_count > DEPTH_C) begin
         post_clamped = DEPTH_C;
      end
   end

   // Trigger condition for the current sample under the latched mode.
   always_comb begin
      trig_hit = 1'b0;
      unique case (mode_q)
         TRIG_IMM:    trig_hit = 1'b1;
         TRIG_PC:     trig_hit = (pc == trig_pc_q);
         TRIG_EXT:    trig_hit = ext_trig;
         TRIG_PC_EXT: trig_hit = (pc == trig_pc_q) && ext_trig;
         default:     trig_hit = 1'b0;
      endcase
   end

   assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + CNT_ONE;

   // Capture FSM next-state: arm wins over any write or trigger in the same cycle.
   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      count_d     = count_q;
      remaining_d = remaining_q;
      tptr_d      = tptr_q;
      mode_d      = mode_q;
      trig_pc_d   = trig_pc_q;
      post_d      = post_q;
      we          = 1'b0;

      if (arm) begin
         state_d   = ST_ARMED;
         wptr_d    = '0;
         count_d   = '0;
         mode_d    = trig_mode_t'(trig_mode);
         trig_pc_d = trig_pc;
         post_d    = post_clamped;
      end else begin
         unique case (state_q)
            ST_ARMED: begin
               if (sample_valid) begin
                  we      = 1'b1;
                  wptr_d  = wptr_q + PTR_ONE;
                  count_d = count_inc;
                  if (trig_hit) begin
                     tptr_d = wptr_q;
                     if (post_q == CNT_ONE) begin
                        state_d = ST_DONE;
                     end else begin
                        remaining_d = post_q - CNT_ONE;
                        state_d     = ST_CAPTURE;
                     end
                  end
               end
            end
            ST_CAPTURE: begin
               if (sample_valid) begin
                  we          = 1'b1;
                  wptr_d      = wptr_q + PTR_ONE;
                  count_d     = count_inc;
                  remaining_d = remaining_q - CNT_ONE;
                  if (remaining_q == CNT_ONE) begin
                     state_d = ST_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wptr_q      <= '0;
         count_q     <= '0;
         remaining_q <= '0;
         tptr_q      <= '0;
         mode_q      <= TRIG_IMM;
         trig_pc_q   <= '0;
         post_q      <= CNT_ONE;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         tptr_q      <= tptr_d;
         mode_q      <= mode_d;
         trig_pc_q   <= trig_pc_d;
         post_q      <= post_d;
      end
   end

   // Once the buffer has filled, the next write slot holds the oldest entry.
   assign oldest     = count_q[ADDR_W] ? wptr_q : '0;
   assign trig_index = tptr_q - oldest;
   assign rd_phys    = oldest + rd_addr;

   assign state = state_q;
   assign done  = (state_q == ST_DONE);
   assign count = count_q;

   trace_ram #(
      .WIDTH  (SAMPLE_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (wptr_q),
      .wdata (sample),
      .raddr (rd_phys),
      .rdata (rd_data)
   );

endmodule
